aes256_cbc_pkcs7_pad: RTL and testbench
=======================================

// Module: aes256_cbc_pkcs7_pad
// PURPOSE
//  Upstream framer for the AES-256-CBC iterative core. Takes a byte-wide AXIS frame
//  (32 key bytes, 16 IV bytes, N message bytes, tlast on the last byte) and forwards it.
//  Encrypt frames get PKCS#7 padding appended; decrypt frames are zero-filled to a block boundary.
//  The output stream therefore always ends on a full 16-byte block, with tlast on its last byte.
// PARAMETERS
//  AXIS_WIDTH   8   tdata width in bits; only 8 is supported (elaboration error otherwise)
//  KEY_BYTES    32  key bytes forwarded before the IV
//  BLOCK_BYTES  16  AES block / IV size in bytes
// PORTS
//  Clk           in   1    clock
//  Rst           in   1    reset; synchronous, active-high; clock Clk
//  S_axis        slave axis_if: tdata[7:0], tvalid, tready, tlast, tkeep[0], tuser (1=encrypt)
//  M_axis        master axis_if: tdata[7:0], tvalid, tready, tlast, tkeep[0]=1, tuser
//  Length_error  out  1    1-cycle pulse: decrypt frame not a multiple of 16 bytes, zero-fill applied
// BEHAVIOUR
//  Reset: state=ST_KEY, byte_cnt=0, blk_cnt=0, pad_cnt=0, encrypt_reg=0, Length_error=0.
//   While Rst=1: S_axis.tready=0, M_axis.tvalid=0.
//  FSM (one-hot): ST_KEY, ST_IV, ST_DATA, ST_PAD.
//  Pass-through states (KEY/IV/DATA): zero latency, combinational.
//   M.tvalid=S.tvalid, S.tready=M.tready, M.tdata=S.tdata, M.tkeep=1.
//   A transfer is S.tvalid & M.tready.
//  encrypt_reg is loaded from S.tuser on the first key byte (byte_cnt==0 in ST_KEY).
//   M.tuser = S.tuser on that byte; otherwise M.tuser = encrypt_reg.
//   S.tuser on later bytes of the frame is ignored.
//  ST_KEY: on byte KEY_BYTES-1 -> ST_IV. S.tlast is ignored; M.tlast=0.
//  ST_IV: on byte 15 without tlast -> ST_DATA, blk_cnt=0. M.tlast=0.
//   Byte 15 with tlast = empty message -> ST_PAD with pad_cnt=16.
//   For an empty decrypt message, Length_error also pulses.
//  ST_DATA: each transfer does blk_cnt <= blk_cnt+1 (4-bit, wraps 15->0).
//   On a transfer with S.tlast, c = (blk_cnt+1) mod 16:
//    encrypt -> M.tlast=0; ST_PAD, pad_cnt = 16-c (c=0 gives 16).
//    decrypt, c==0 -> M.tlast=1; ST_KEY.
//    decrypt, c!=0 -> M.tlast=0; ST_PAD, pad_cnt = 16-c; Length_error pulses next cycle.
//  ST_PAD: S.tready=0, M.tvalid=1.
//   M.tdata = encrypt_reg ? pad_len : 8'h00, where pad_len is pad_cnt latched at entry (1..16).
//   Each M transfer decrements pad_cnt. M.tlast=1 when pad_cnt==1.
//   Transfer with pad_cnt==1 -> ST_KEY, byte_cnt=0.
//  Width rules: byte_cnt 6 bits (0..47, covers key+IV); blk_cnt 4 bits; pad_cnt and pad_len 5 bits.
//  Backpressure: M.tready=0 holds all state. In ST_PAD, tdata and tlast stay stable while tvalid=1.
//  Back-to-back frames: the cycle after the final tlast transfer accepts key byte 0 of the next frame.
//   No bubble is required beyond the ST_KEY entry.
//  Reset mid-frame: abort immediately and return to the reset state.
//   The downstream core is expected to be reset on the same Rst.
// STRUCTURE
//  Shared package aes_pkg holds the constants AES_BLOCK_BYTES=16 and AES256_KEY_BYTES=32,
//   plus the PKCS#7 function pkcs7_pad_len(logic [3:0] c) -> logic [4:0].
//   The unpad stage downstream of the core reuses the same function.
//  No sub-module: FSM, three counters and the output mux sit in one always_comb/always_ff set.
//  The state enum stays local to this module.
// TESTING
//  1 Encrypt, 16-byte msg 00..0F, M.tready=1 -> 80 output bytes.
//    Last 16 bytes are 0x10; tlast only on byte 79; tuser=1 throughout.
//  2 Encrypt, 5-byte msg -> 64 output bytes; last 11 are 0x0B; tlast on byte 63.
//  3 Encrypt, empty msg (tlast on IV byte 15) -> 64 output bytes; bytes 48..63 = 0x10; tlast on 63.
//  4 Decrypt, 32-byte msg -> 80 bytes forwarded unchanged; tlast on byte 79; Length_error stays 0.
//  5 Decrypt, 20-byte msg -> 12 zero bytes appended; tlast on byte 79; Length_error pulses once.
//  6 Random M.tready (50%) and S.tvalid gaps over 3 back-to-back frames.
//    Output matches the golden model byte-for-byte.
//    Assert Rst at byte 40 of frame 2 -> tvalid=0 next cycle; frame 3 processes cleanly.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES sizes and the PKCS#7 pad-length rule used by the framer and the unpad stage
package aes_pkg;
  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES256_KEY_BYTES = 32;
  function automatic logic [4:0] pkcs7_pad_len(input logic [3:0] c);
    return 5'd16 - {1'b0, c};
  endfunction
endpackage

// File: rtl/aes256_cbc_pkcs7_pad.sv
// aes256_cbc_pkcs7_pad: byte AXIS framer (key, IV, message) adding PKCS#7 pad on encrypt or zero-fill on decrypt; ports Clk, Rst, S_axis_* in, M_axis_* out, Length_error pulse
module aes256_cbc_pkcs7_pad
  import aes_pkg::*;
#(
  parameter int AXIS_WIDTH = 8,
  parameter int KEY_BYTES = AES256_KEY_BYTES,
  parameter int BLOCK_BYTES = AES_BLOCK_BYTES
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [AXIS_WIDTH-1:0] S_axis_tdata,
  input  logic                  S_axis_tvalid,
  output logic                  S_axis_tready,
  input  logic                  S_axis_tlast,
  input  logic                  S_axis_tkeep,
  input  logic                  S_axis_tuser,
  output logic [AXIS_WIDTH-1:0] M_axis_tdata,
  output logic                  M_axis_tvalid,
  input  logic                  M_axis_tready,
  output logic                  M_axis_tlast,
  output logic                  M_axis_tkeep,
  output logic                  M_axis_tuser,
  output logic                  Length_error
);
  if (AXIS_WIDTH != 8) begin : g_width_check
    $error("aes256_cbc_pkcs7_pad supports AXIS_WIDTH=8 only");
  end
  typedef enum logic [3:0] {
    ST_KEY  = 4'b0001,
    ST_IV   = 4'b0010,
    ST_DATA = 4'b0100,
    ST_PAD  = 4'b1000
  } state_t;
  state_t state, state_nxt;
  logic [5:0] byte_cnt;
  logic [3:0] blk_cnt;
  logic [3:0] c;
  logic [4:0] pad_cnt;
  logic [4:0] pad_len;
  logic [4:0] pad_new;
  logic encrypt_reg;
  logic s_xfer;
  logic key_last;
  logic iv_last;
  logic enter_pad;
  logic unused_tkeep;
  assign unused_tkeep = S_axis_tkeep;
  assign c = blk_cnt + 4'd1;
  assign s_xfer = S_axis_tvalid & S_axis_tready;
  assign key_last = byte_cnt == 6'(KEY_BYTES - 1);
  assign iv_last = byte_cnt == 6'(KEY_BYTES + BLOCK_BYTES - 1);
  assign enter_pad = state != ST_PAD && state_nxt == ST_PAD;
  assign pad_new = pkcs7_pad_len(state == ST_IV ? 4'd0 : c);
  always_ff @(posedge Clk)
    if (Rst) state <= ST_KEY;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      ST_KEY:  state_nxt = s_xfer && key_last ? ST_IV : ST_KEY;
      ST_IV:   state_nxt = !(s_xfer && iv_last) ? ST_IV : S_axis_tlast ? ST_PAD : ST_DATA;
      ST_DATA: state_nxt = !(s_xfer && S_axis_tlast) ? ST_DATA : (!encrypt_reg && c == 4'd0) ? ST_KEY : ST_PAD;
      ST_PAD:  state_nxt = M_axis_tready && pad_cnt == 5'd1 ? ST_KEY : ST_PAD;
      default: state_nxt = ST_KEY;
    endcase
  end
  always_comb begin
    S_axis_tready = !Rst && state != ST_PAD && M_axis_tready;
    M_axis_tvalid = !Rst && (state == ST_PAD || S_axis_tvalid);
    M_axis_tdata = state == ST_PAD ? (encrypt_reg ? AXIS_WIDTH'(pad_len) : '0) : S_axis_tdata;
    M_axis_tlast = state == ST_PAD ? pad_cnt == 5'd1 : state == ST_DATA && S_axis_tlast && !encrypt_reg && c == 4'd0;
    M_axis_tuser = state == ST_KEY && byte_cnt == 6'd0 ? S_axis_tuser : encrypt_reg;
    M_axis_tkeep = 1'b1;
  end
  always_ff @(posedge Clk)
    if (Rst) begin
      byte_cnt <= '0;
      blk_cnt <= '0;
      pad_cnt <= '0;
      pad_len <= '0;
      encrypt_reg <= 1'b0;
      Length_error <= 1'b0;
    end else begin
      if (s_xfer && state == ST_KEY && byte_cnt == 6'd0) encrypt_reg <= S_axis_tuser;
      if (s_xfer && (state == ST_KEY || state == ST_IV)) byte_cnt <= state == ST_IV && iv_last ? 6'd0 : byte_cnt + 6'd1;
      if (s_xfer && state == ST_IV) blk_cnt <= 4'd0;
      else if (s_xfer && state == ST_DATA) blk_cnt <= c;
      if (enter_pad) begin
        pad_cnt <= pad_new;
        pad_len <= pad_new;
      end else if (state == ST_PAD && M_axis_tready) pad_cnt <= pad_cnt - 5'd1;
      Length_error <= enter_pad && !encrypt_reg;
    end
endmodule

// File: tb/tb_aes256_cbc_pkcs7_pad.sv
// tb_aes256_cbc_pkcs7_pad: directed frames checked byte-for-byte against a queue model of the framed output
module tb_aes256_cbc_pkcs7_pad;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic [7:0] S_axis_tdata = '0;
  logic S_axis_tvalid = 1'b0;
  logic S_axis_tready;
  logic S_axis_tlast = 1'b0;
  logic S_axis_tkeep = 1'b1;
  logic S_axis_tuser = 1'b0;
  logic [7:0] M_axis_tdata;
  logic M_axis_tvalid;
  logic M_axis_tready = 1'b1;
  logic M_axis_tlast;
  logic M_axis_tkeep;
  logic M_axis_tuser;
  logic Length_error;
  aes256_cbc_pkcs7_pad dut (
    .Clk(Clk), .Rst(Rst),
    .S_axis_tdata(S_axis_tdata), .S_axis_tvalid(S_axis_tvalid), .S_axis_tready(S_axis_tready),
    .S_axis_tlast(S_axis_tlast), .S_axis_tkeep(S_axis_tkeep), .S_axis_tuser(S_axis_tuser),
    .M_axis_tdata(M_axis_tdata), .M_axis_tvalid(M_axis_tvalid), .M_axis_tready(M_axis_tready),
    .M_axis_tlast(M_axis_tlast), .M_axis_tkeep(M_axis_tkeep), .M_axis_tuser(M_axis_tuser),
    .Length_error(Length_error)
  );
  always #5 Clk = ~Clk;
  int nvec = 0;
  int nerr = 0;
  int le_count = 0;
  int le_exp = 0;
  int cnt = 0;
  int nbytes = 0;
  int fr_len[$];
  logic [7:0] fr_last[$];
  logic [9:0] q[$];
  logic [9:0] me;
  bit rand_ready = 1'b0;
  initial forever begin
    @(posedge Clk);
    #1;
    M_axis_tready = rand_ready ? 1'($urandom % 2) : 1'b1;
  end
  always @(negedge Clk) begin
    if (!Rst) begin
      if (M_axis_tvalid && M_axis_tready) begin
        nvec++;
        if (q.size() == 0) begin
          nerr++;
          $display("FAIL stream: unexpected byte data=%h last=%b", M_axis_tdata, M_axis_tlast);
        end else begin
          me = q.pop_front();
          if ({M_axis_tuser, M_axis_tlast, M_axis_tdata} !== me || M_axis_tkeep !== 1'b1) begin
            nerr++;
            $display("FAIL stream byte %0d: got user=%b last=%b data=%h keep=%b, want user=%b last=%b data=%h keep=1",
                     nbytes, M_axis_tuser, M_axis_tlast, M_axis_tdata, M_axis_tkeep, me[9], me[8], me[7:0]);
          end
        end
        nbytes++;
        cnt++;
        if (M_axis_tlast) begin
          fr_len.push_back(cnt);
          fr_last.push_back(M_axis_tdata);
          cnt = 0;
        end
      end
      if (Length_error) le_count++;
    end else cnt = 0;
  end
  task automatic chk(input string name, input int got, input int want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask
  task automatic send(input bit enc, input int len, input bit rnd, input int abort_at);
    logic [7:0] b[$];
    bit full;
    int p;
    bit hs;
    int t;
    for (int i = 0; i < 48; i++) b.push_back(i < 32 ? 8'(8'hA0 + i) : 8'(8'h30 + i));
    for (int i = 0; i < len; i++) b.push_back(rnd ? 8'($urandom) : 8'(i));
    full = len % 16 == 0 && len > 0;
    for (int i = 0; i < b.size(); i++) q.push_back({enc, !enc && full && i == b.size() - 1, b[i]});
    p = enc ? 16 - len % 16 : (full ? 0 : 16 - len % 16);
    for (int j = 0; j < p; j++) q.push_back({enc, j == p - 1, enc ? 8'(p) : 8'h00});
    for (int i = 0; i < b.size(); i++) begin
      if (rnd) while ($urandom % 2 == 1) begin
        S_axis_tvalid = 1'b0;
        @(posedge Clk);
        #1;
      end
      if (i == abort_at) begin
        Rst = 1'b1;
        S_axis_tvalid = 1'b0;
        @(negedge Clk);
        chk("reset tvalid", int'(M_axis_tvalid), 0);
        chk("reset tready", int'(S_axis_tready), 0);
        @(posedge Clk);
        #1;
        q.delete();
        Rst = 1'b0;
        return;
      end
      S_axis_tvalid = 1'b1;
      S_axis_tdata = b[i];
      S_axis_tlast = i == b.size() - 1;
      S_axis_tuser = i == 0 ? enc : !enc;
      hs = 1'b0;
      t = 0;
      while (!hs) begin
        @(negedge Clk);
        hs = S_axis_tready;
        @(posedge Clk);
        #1;
        if (++t > 2000) begin
          chk("input handshake timeout", 0, 1);
          hs = 1'b1;
        end
      end
    end
    S_axis_tvalid = 1'b0;
    S_axis_tlast = 1'b0;
    le_exp += int'(!enc && !full);
  endtask
  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 3000) begin
      @(posedge Clk);
      t++;
    end
    chk("output drained", q.size(), 0);
    repeat (3) @(posedge Clk);
    #1;
    chk("length_error pulses", le_count, le_exp);
  endtask
  initial begin
    S_axis_tvalid = 1'b1;
    S_axis_tdata = 8'h5A;
    @(negedge Clk);
    chk("reset tvalid", int'(M_axis_tvalid), 0);
    chk("reset tready", int'(S_axis_tready), 0);
    chk("reset length_error", int'(Length_error), 0);
    repeat (2) @(posedge Clk);
    #1;
    S_axis_tvalid = 1'b0;
    Rst = 1'b0;
    send(1'b1, 16, 1'b0, -1);
    drain();
    send(1'b1, 5, 1'b0, -1);
    drain();
    send(1'b1, 0, 1'b0, -1);
    drain();
    send(1'b0, 32, 1'b0, -1);
    drain();
    chk("test4 length_error", le_count, 0);
    send(1'b0, 20, 1'b0, -1);
    drain();
    chk("test5 length_error", le_count, 1);
    chk("frames seen", fr_len.size(), 5);
    chk("t1 length", fr_len[0], 80);
    chk("t1 last byte", int'(fr_last[0]), 16);
    chk("t2 length", fr_len[1], 64);
    chk("t2 last byte", int'(fr_last[1]), 11);
    chk("t3 length", fr_len[2], 64);
    chk("t3 last byte", int'(fr_last[2]), 16);
    chk("t4 length", fr_len[3], 80);
    chk("t4 last byte", int'(fr_last[3]), 31);
    chk("t5 length", fr_len[4], 80);
    chk("t5 last byte", int'(fr_last[4]), 0);
    rand_ready = 1'b1;
    send(1'b1, 21, 1'b1, -1);
    send(1'b0, 30, 1'b1, 40);
    send(1'b0, 7, 1'b1, -1);
    drain();
    rand_ready = 1'b0;
    chk("t6 frames seen", fr_len.size(), 7);
    chk("t6 frame1 length", fr_len[5], 80);
    chk("t6 frame3 length", fr_len[6], 64);
    chk("t6 length_error", le_count, 2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
